// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side command responder: bank/timing tracking, SDR burst
// engine and a small backing array for reads and writes.
module ddr3_cmd_responder #(
  parameter int CL   = 5,
  parameter int CWL  = 5,
  parameter int tRCD = 3,
  parameter int tRP  = 3,
  parameter int tRFC = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr,
  input  logic [2:0]  BA,
  input  logic        LDM,
  input  logic        UDM,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic        DQ_oe,
  output logic        LDQS,
  output logic        UDQS,
  output logic [7:0]  bank_open,
  output logic        refresh_busy,
  output logic [4:0]  err
);

  typedef enum logic [2:0] {
    C_MRS, C_REF, C_PRE, C_ACT, C_WR, C_RD, C_ZQ, C_NOP
  } cmd_e;

  typedef enum logic {B_IDLE, B_RUN} bst_e;

  localparam logic [7:0] RCD_L = 8'(tRCD - 1);
  localparam logic [7:0] RP_L  = 8'(tRP - 1);
  localparam logic [7:0] RFC_L = 8'(tRFC);
  localparam logic [7:0] RD_L  = 8'(CL - 2);
  localparam logic [7:0] WR_L  = 8'(CWL - 1);

  logic [7:0]  trcd [8];
  logic [7:0]  trp  [8];
  logic [1:0]  row  [8];
  logic [14:0] mr   [4];
  logic [7:0]  rfc;
  logic [15:0] mem  [256];

  bst_e        bst;
  logic        b_rd, b_ap, b_bc4;
  logic [2:0]  b_bank, b_col, b_idx;
  logic [1:0]  b_row;
  logic [7:0]  b_cnt;
  logic        ap_close;
  logic [2:0]  ap_bank;

  cmd_e        cmd;
  logic        beat, last, wr_en;
  logic [2:0]  col;
  logic [7:0]  maddr;
  logic        ref_blk, closing, act_ok, rw_ok;

  always_comb begin
    cmd = C_NOP;
    if (!CS) cmd = cmd_e'({RAS, CAS, WE});
  end

  assign beat    = (bst == B_RUN) && (b_cnt == 8'd0);
  assign last    = b_idx == (b_bc4 ? 3'd3 : 3'd7);
  assign col     = b_bc4 ? {b_col[2], 2'(b_col[1:0] + b_idx[1:0])}
                         : 3'(b_col + b_idx);
  assign maddr   = {b_bank, b_row, col};
  assign wr_en   = beat && !b_rd;

  // refresh window blocks commands until the counter reaches its final cycle
  assign ref_blk = rfc > 8'd1;
  assign closing = ap_close && (ap_bank == BA);
  assign act_ok  = !bank_open[BA] && (trp[BA] == 8'd0) && !closing;
  assign rw_ok   = bank_open[BA] && (trcd[BA] == 8'd0) && !closing;

  assign refresh_busy = rfc != 8'd0;
  assign LDQS = DQ_oe;
  assign UDQS = DQ_oe;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      if (!LDM) mem[maddr][7:0]  <= DQ_in[7:0];
      if (!UDM) mem[maddr][15:8] <= DQ_in[15:8];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DQ_out    <= '0;
      DQ_oe     <= 1'b0;
      bank_open <= '0;
      err       <= '0;
      rfc       <= '0;
      bst       <= B_IDLE;
      b_rd      <= 1'b0;
      b_ap      <= 1'b0;
      b_bc4     <= 1'b0;
      b_bank    <= '0;
      b_col     <= '0;
      b_idx     <= '0;
      b_row     <= '0;
      b_cnt     <= '0;
      ap_close  <= 1'b0;
      ap_bank   <= '0;
      for (int b = 0; b < 8; b++) begin
        trcd[b] <= '0;
        trp[b]  <= '0;
        row[b]  <= '0;
      end
      for (int m = 0; m < 4; m++) mr[m] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (trcd[b] != 8'd0) trcd[b] <= trcd[b] - 8'd1;
        if (trp[b] != 8'd0)  trp[b]  <= trp[b] - 8'd1;
      end
      if (rfc != 8'd0) rfc <= rfc - 8'd1;
      DQ_oe  <= 1'b0;
      DQ_out <= '0;

      if (ap_close) begin
        bank_open[ap_bank] <= 1'b0;
        trp[ap_bank]       <= RP_L;
        ap_close           <= 1'b0;
      end

      unique case (bst)
        B_RUN: begin
          if (b_cnt != 8'd0) begin
            b_cnt <= b_cnt - 8'd1;
          end else begin
            if (b_rd) begin
              DQ_out <= mem[maddr];
              DQ_oe  <= 1'b1;
            end
            b_idx <= b_idx + 3'd1;
            if (last) begin
              bst      <= B_IDLE;
              ap_close <= b_ap;
              ap_bank  <= b_bank;
            end
          end
        end
        default: ;
      endcase

      if (cmd != C_NOP && ref_blk) begin
        err[3] <= 1'b1;
      end else begin
        unique case (cmd)
          C_MRS: mr[BA[1:0]] <= Addr;
          C_REF: begin
            if (|bank_open) err[2] <= 1'b1;
            else            rfc    <= RFC_L;
          end
          C_PRE: begin
            for (int b = 0; b < 8; b++) begin
              if ((Addr[10] || BA == 3'(b)) && bank_open[b]) begin
                bank_open[b] <= 1'b0;
                trp[b]       <= RP_L;
              end
            end
          end
          C_ACT: begin
            if (!act_ok) begin
              err[0] <= 1'b1;
            end else begin
              bank_open[BA] <= 1'b1;
              row[BA]       <= Addr[1:0];
              trcd[BA]      <= RCD_L;
            end
          end
          C_WR, C_RD: begin
            if (!rw_ok) begin
              err[1] <= 1'b1;
            end else if (bst != B_IDLE) begin
              err[4] <= 1'b1;
            end else begin
              bst    <= B_RUN;
              b_rd   <= cmd == C_RD;
              b_ap   <= Addr[10];
              b_bc4  <= !Addr[12];
              b_bank <= BA;
              b_row  <= row[BA];
              b_col  <= Addr[2:0];
              b_idx  <= '0;
              b_cnt  <= (cmd == C_RD) ? RD_L : WR_L;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: timing windows, burst ordering,
// masks, auto-precharge, refresh and mid-burst reset.
module tb_ddr3_cmd_responder;

  localparam int CL   = 5;
  localparam int CWL  = 5;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TRFC = 10;

  localparam logic [2:0] K_REF = 3'b001;
  localparam logic [2:0] K_PRE = 3'b010;
  localparam logic [2:0] K_ACT = 3'b011;
  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_RD  = 3'b101;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [14:0] Addr = '0;
  logic [2:0]  BA = '0;
  logic        LDM = 1'b0, UDM = 1'b0;
  logic [15:0] DQ_in = '0;
  logic [15:0] DQ_out;
  logic        DQ_oe, LDQS, UDQS;
  logic [7:0]  bank_open;
  logic        refresh_busy;
  logic [4:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  ddr3_cmd_responder #(
    .CL(CL), .CWL(CWL), .tRCD(TRCD), .tRP(TRP), .tRFC(TRFC)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr(Addr), .BA(BA), .LDM(LDM), .UDM(UDM), .DQ_in(DQ_in),
    .DQ_out(DQ_out), .DQ_oe(DQ_oe), .LDQS(LDQS), .UDQS(UDQS),
    .bank_open(bank_open), .refresh_busy(refresh_busy), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] ba,
                       input logic [14:0] a);
    CS = 1'b0;
    {RAS, CAS, WE} = c;
    BA = ba;
    Addr = a;
    @(negedge CLK);
    CS = 1'b1;
    {RAS, CAS, WE} = 3'b111;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    CS = 1'b1;
    {RAS, CAS, WE} = 3'b111;
    Addr = '0;
    BA = '0;
    LDM = 1'b0;
    UDM = 1'b0;
    DQ_in = '0;
    idle(2);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({DQ_oe, LDQS, UDQS} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_oe: got %b want 000", {DQ_oe, LDQS, UDQS});
    end
    n_cmp++;
    if (DQ_out !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_dq: got %h want 0000", DQ_out);
    end
    n_cmp++;
    if (bank_open !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_bank: got %h want 00", bank_open);
    end
    n_cmp++;
    if (refresh_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rb: got %b want 0", refresh_busy);
    end
    n_cmp++;
    if (err !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 00000", err);
    end
  endtask

  task automatic test_trcd();
    do_reset();
    issue(K_ACT, 3'd2, 15'd1);
    n_cmp++;
    if (bank_open !== 8'h04) begin
      n_bad++;
      $display("FAIL trcd_open: got %h want 04", bank_open);
    end
    idle(1);
    issue(K_RD, 3'd2, 15'h1000);
    n_cmp++;
    if (err !== 5'b00010) begin
      n_bad++;
      $display("FAIL trcd_err: got %b want 00010", err);
    end
    issue(K_RD, 3'd2, 15'h1000);
    for (int k = 0; k < CL + 9; k++) begin
      logic e;
      e = (k >= CL - 1) && (k <= CL + 6);
      n_cmp++;
      if (DQ_oe !== e) begin
        n_bad++;
        $display("FAIL trcd_oe k=%0d: got %b want %b", k, DQ_oe, e);
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (err !== 5'b00010) begin
      n_bad++;
      $display("FAIL trcd_err_end: got %b want 00010", err);
    end
  endtask

  task automatic test_bl8_wrap();
    logic [15:0] e [8];
    e = '{16'h1003, 16'h1004, 16'h1005, 16'h1006,
          16'h1007, 16'h1000, 16'h1001, 16'h1002};
    do_reset();
    issue(K_ACT, 3'd0, 15'd0);
    idle(TRCD - 1);
    issue(K_WR, 3'd0, 15'h1005);
    idle(CWL - 1);
    for (int i = 0; i < 8; i++) begin
      DQ_in = 16'h1000 + 16'(i);
      @(negedge CLK);
    end
    issue(K_RD, 3'd0, 15'h1000);
    idle(CL - 1);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({DQ_oe, DQ_out} !== {1'b1, e[i]}) begin
        n_bad++;
        $display("FAIL bl8_beat%0d: got oe=%b %h want oe=1 %h",
                 i, DQ_oe, DQ_out, e[i]);
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (DQ_oe !== 1'b0 || err !== 5'b0) begin
      n_bad++;
      $display("FAIL bl8_end: got oe=%b err=%b want 0 00000", DQ_oe, err);
    end
  endtask

  task automatic test_bc4_mask();
    logic [15:0] d [4];
    logic [15:0] e [4];
    logic [3:0]  lm;
    d  = '{16'h2222, 16'hAB00, 16'h4444, 16'h5555};
    e  = '{16'h4444, 16'h5555, 16'h2222, 16'hAB11};
    lm = 4'b0010;
    do_reset();
    issue(K_ACT, 3'd0, 15'd0);
    idle(TRCD - 1);
    issue(K_WR, 3'd0, 15'h0004);
    idle(CWL - 1);
    for (int i = 0; i < 4; i++) begin
      DQ_in = 16'h1111;
      @(negedge CLK);
    end
    issue(K_WR, 3'd0, 15'h0006);
    idle(CWL - 1);
    for (int i = 0; i < 4; i++) begin
      DQ_in = d[i];
      LDM = lm[i];
      @(negedge CLK);
    end
    LDM = 1'b0;
    issue(K_RD, 3'd0, 15'h0004);
    idle(CL - 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({DQ_oe, DQ_out} !== {1'b1, e[i]}) begin
        n_bad++;
        $display("FAIL bc4_beat%0d: got oe=%b %h want oe=1 %h",
                 i, DQ_oe, DQ_out, e[i]);
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (DQ_oe !== 1'b0 || err !== 5'b0) begin
      n_bad++;
      $display("FAIL bc4_end: got oe=%b err=%b want 0 00000", DQ_oe, err);
    end
  endtask

  task automatic test_autoprecharge();
    do_reset();
    issue(K_ACT, 3'd1, 15'd0);
    idle(TRCD - 1);
    issue(K_WR, 3'd1, 15'h1400);
    idle(CWL - 1);
    for (int i = 0; i < 8; i++) begin
      DQ_in = 16'h5A00 + 16'(i);
      @(negedge CLK);
    end
    n_cmp++;
    if (bank_open !== 8'h02) begin
      n_bad++;
      $display("FAIL ap_last: got %h want 02", bank_open);
    end
    @(negedge CLK);
    n_cmp++;
    if (bank_open !== 8'h00) begin
      n_bad++;
      $display("FAIL ap_close: got %h want 00", bank_open);
    end
    idle(TRP - 2);
    issue(K_ACT, 3'd1, 15'd0);
    n_cmp++;
    if (err !== 5'b00001 || bank_open !== 8'h00) begin
      n_bad++;
      $display("FAIL ap_early_act: got err=%b open=%h want 00001 00",
               err, bank_open);
    end
    issue(K_ACT, 3'd1, 15'd0);
    n_cmp++;
    if (err !== 5'b00001 || bank_open !== 8'h02) begin
      n_bad++;
      $display("FAIL ap_act: got err=%b open=%h want 00001 02",
               err, bank_open);
    end
  endtask

  task automatic test_refresh();
    do_reset();
    issue(K_ACT, 3'd3, 15'd0);
    issue(K_REF, 3'd0, 15'd0);
    n_cmp++;
    if (err !== 5'b00100 || refresh_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ref_open: got err=%b rb=%b want 00100 0",
               err, refresh_busy);
    end
    issue(K_PRE, 3'd0, 15'h0400);
    n_cmp++;
    if (bank_open !== 8'h00) begin
      n_bad++;
      $display("FAIL ref_pre: got %h want 00", bank_open);
    end
    idle(TRP - 1);
    issue(K_REF, 3'd0, 15'd0);
    for (int k = 0; k < TRFC; k++) begin
      if (k == 5) begin
        CS = 1'b1;
        {RAS, CAS, WE} = 3'b111;
        n_cmp++;
        if (err !== 5'b01100 || bank_open !== 8'h00) begin
          n_bad++;
          $display("FAIL ref_act_in_window: got err=%b open=%h want 01100 00",
                   err, bank_open);
        end
      end
      n_cmp++;
      if (refresh_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL ref_busy k=%0d: got %b want 1", k, refresh_busy);
      end
      if (k == 4) begin
        CS = 1'b0;
        {RAS, CAS, WE} = K_ACT;
        BA = 3'd3;
        Addr = '0;
      end
      if (k < TRFC - 1) @(negedge CLK);
    end
    issue(K_ACT, 3'd3, 15'd0);
    n_cmp++;
    if (refresh_busy !== 1'b0 || bank_open !== 8'h08 || err !== 5'b01100) begin
      n_bad++;
      $display("FAIL ref_after: got rb=%b open=%h err=%b want 0 08 01100",
               refresh_busy, bank_open, err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(K_ACT, 3'd0, 15'd0);
    idle(TRCD - 1);
    issue(K_RD, 3'd0, 15'h1000);
    idle(1);
    issue(K_RD, 3'd0, 15'h1000);
    n_cmp++;
    if (err !== 5'b10000) begin
      n_bad++;
      $display("FAIL b2b_err: got %b want 10000", err);
    end
    for (int k = 2; k < CL + 11; k++) begin
      logic e;
      e = (k >= CL - 1) && (k <= CL + 6);
      n_cmp++;
      if (DQ_oe !== e) begin
        n_bad++;
        $display("FAIL b2b_oe k=%0d: got %b want %b", k, DQ_oe, e);
      end
      @(negedge CLK);
    end
    issue(K_RD, 3'd0, 15'h1000);
    idle(CL + 1);
    n_cmp++;
    if (DQ_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_oe: got %b want 1", DQ_oe);
    end
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if ({DQ_oe, LDQS, UDQS} !== 3'b000 || bank_open !== 8'h00
        || err !== 5'b0 || DQ_out !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_mid: got oe=%b open=%h err=%b dq=%h want 0 00 00000 0000",
               DQ_oe, bank_open, err, DQ_out);
    end
    @(negedge CLK);
    RESET = 1'b0;
    idle(CL + 8);
    n_cmp++;
    if (DQ_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after_oe: got %b want 0", DQ_oe);
    end
  endtask

  initial begin
    test_reset();
    test_trcd();
    test_bl8_wrap();
    test_bc4_mask();
    test_autoprecharge();
    test_refresh();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
